// File: rtl/instr_issue.sv
// Single-entry instruction issue stage with a 16-register busy scoreboard.
// Holds one decoded instruction and presents it downstream once its registers are free.
module instr_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [3:0]  opcode,
  output logic [3:0]  dest_sel,
  output logic [3:0]  src1_sel,
  output logic [3:0]  src2_sel,
  output logic [15:0] imm,
  input  logic        wb_valid,
  input  logic [3:0]  wb_dest,
  output logic [15:0] busy,
  output logic [7:0]  stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_STALL} state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] busy_q, busy_d;
  logic [7:0]  stall_q, stall_d;

  logic [15:0] wb_mask;
  logic [15:0] busy_eff;
  logic        held;
  logic        hazard;
  logic        fire;
  logic        accept;

  assign opcode    = instr_q[31:28];
  assign dest_sel  = instr_q[27:24];
  assign src1_sel  = instr_q[23:20];
  assign src2_sel  = instr_q[19:16];
  assign imm       = instr_q[15:0];
  assign busy      = busy_q;
  assign stall_cnt = stall_q;

  // A writeback landing this cycle releases its register immediately.
  assign wb_mask  = wb_valid ? (16'h0001 << wb_dest) : 16'h0000;
  assign busy_eff = busy_q & ~wb_mask;
  assign held     = (state_q != S_IDLE);
  assign hazard   = (opcode != 4'h0) &&
                    (busy_eff[src1_sel] || busy_eff[src2_sel] || busy_eff[dest_sel]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= 32'h0;
      busy_q  <= 16'h0;
      stall_q <= 8'h0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_HOLD;
      end
      S_HOLD, S_STALL: begin
        if (fire && accept)  state_d = S_HOLD;
        else if (fire)       state_d = S_IDLE;
        else if (hazard)     state_d = S_STALL;
        else                 state_d = S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // instr_ready follows issue_ready combinationally so a slot freed by fire refills at once.
  always_comb begin
    issue_valid = held && !hazard;
    fire        = issue_valid && issue_ready;
    instr_ready = rst_n && (!held || fire);
    accept      = instr_valid && instr_ready;
  end

  always_comb begin
    instr_d = accept ? instr : instr_q;
    busy_d  = busy_eff;
    if (fire && (opcode != 4'h0)) busy_d[dest_sel] = 1'b1;
    stall_d = stall_q;
    if (held && hazard && (stall_q != 8'hFF)) stall_d = stall_q + 8'h01;
  end

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural scoreboard model.
module tb_instr_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  opcode, dest_sel, src1_sel, src2_sel;
  logic [15:0] imm;
  logic        wb_valid;
  logic [3:0]  wb_dest;
  logic [15:0] busy;
  logic [7:0]  stall_cnt;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state
  bit          m_held;
  logic [31:0] m_instr;
  bit          m_busy [16];
  int          m_stall;
  bit          m_fire, m_accept, m_hazard;

  instr_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .opcode      (opcode),
    .dest_sel    (dest_sel),
    .src1_sel    (src1_sel),
    .src2_sel    (src2_sel),
    .imm         (imm),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .busy        (busy),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] model_busy();
    logic [15:0] v;
    for (int r = 0; r < 16; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic bit pending(input int r);
    return m_busy[r] && !(wb_valid && (int'(wb_dest) == r));
  endfunction

  // Drive one cycle of inputs and compare every visible output with the model.
  task automatic apply(input bit iv, input logic [31:0] ins, input bit ir,
                       input bit wv, input logic [3:0] wd);
    logic [3:0] op, d, s1, s2;
    bit exp_iv, exp_ir;
    @(negedge clk);
    instr_valid = iv; instr = ins; issue_ready = ir; wb_valid = wv; wb_dest = wd;
    #1;
    op = m_instr[31:28]; d = m_instr[27:24]; s1 = m_instr[23:20]; s2 = m_instr[19:16];
    m_hazard = m_held && (op != 4'h0) &&
               (pending(int'(s1)) || pending(int'(s2)) || pending(int'(d)));
    exp_iv   = m_held && !m_hazard;
    m_fire   = exp_iv && ir;
    exp_ir   = !m_held || m_fire;
    m_accept = iv && exp_ir;
    check("issue_valid", {31'h0, issue_valid}, {31'h0, exp_iv});
    check("instr_ready", {31'h0, instr_ready}, {31'h0, exp_ir});
    check("busy", {16'h0, busy}, {16'h0, model_busy()});
    check("stall_cnt", {24'h0, stall_cnt}, m_stall);
    if (m_held)
      check("fields", {opcode, dest_sel, src1_sel, src2_sel, imm}, m_instr);
    $display("cyc iv=%0b ins=%h ir=%0b wb=%0b/%0d -> rdy=%0b ivld=%0b busy=%h stall=%0d",
             iv, ins, ir, wv, wd, instr_ready, issue_valid, busy, stall_cnt);
  endtask

  // Advance the model across the clock edge that follows apply().
  task automatic commit();
    if (wb_valid) m_busy[wb_dest] = 1'b0;
    if (m_fire && (m_instr[31:28] != 4'h0)) m_busy[m_instr[27:24]] = 1'b1;
    if (m_hazard && m_stall < 255) m_stall++;
    if (m_accept) begin
      m_held  = 1'b1;
      m_instr = instr;
    end else if (m_fire) begin
      m_held = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic step(input bit iv, input logic [31:0] ins, input bit ir,
                      input bit wv, input logic [3:0] wd);
    apply(iv, ins, ir, wv, wd);
    commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0; instr = 32'h0; issue_ready = 1'b0; wb_valid = 1'b0; wb_dest = 4'h0;
    #1;
    check("rst_issue_valid", {31'h0, issue_valid}, 32'h0);
    check("rst_instr_ready", {31'h0, instr_ready}, 32'h0);
    check("rst_busy", {16'h0, busy}, 32'h0);
    check("rst_stall", {24'h0, stall_cnt}, 32'h0);
    check("rst_fields", {opcode, dest_sel, src1_sel, src2_sel, imm}, 32'h0);
    m_held = 1'b0; m_instr = 32'h0; m_stall = 0;
    for (int r = 0; r < 16; r++) m_busy[r] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_instr_ready", {31'h0, instr_ready}, 32'h1);
    $display("reset released");
  endtask

  initial begin
    int st;
    rst_n = 1'b1;
    instr_valid = 1'b0; instr = 32'h0; issue_ready = 1'b0; wb_valid = 1'b0; wb_dest = 4'h0;
    do_reset();

    // Basic decode and scoreboard set
    step(1, 32'h1321_00AB, 1, 0, 4'h0);
    apply(0, 32'h0, 1, 0, 4'h0);
    check("dec_valid", {31'h0, issue_valid}, 32'h1);
    check("dec_fields", {opcode, dest_sel, src1_sel, src2_sel, imm}, 32'h1321_00AB);
    commit();
    apply(0, 32'h0, 1, 0, 4'h0);
    check("dec_busy", {16'h0, busy}, 32'h0000_0008);
    commit();

    // RAW hazard, stall counting, same-cycle writeback bypass
    do_reset();
    step(1, 32'h1321_0000, 1, 0, 4'h0);
    step(0, 32'h0, 1, 0, 4'h0);
    step(1, 32'h2430_0000, 1, 0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 32'h0, 1, 0, 4'h0);
      check("raw_stall_valid", {31'h0, issue_valid}, 32'h0);
      check("raw_stall_cnt", {24'h0, stall_cnt}, i);
      commit();
    end
    apply(0, 32'h0, 1, 1, 4'h3);
    check("raw_bypass_valid", {31'h0, issue_valid}, 32'h1);
    commit();

    // Back-to-back fill of the whole scoreboard, then a NOP
    do_reset();
    for (int r = 0; r < 16; r++) begin
      logic [3:0] rr;
      rr = 4'(r);
      step(1, {4'h1, rr, rr, rr, 16'h0}, 1, 0, 4'h0);
    end
    step(0, 32'h0, 1, 0, 4'h0);
    apply(1, 32'h0567_0000, 1, 0, 4'h0);
    check("nop_busy_full", {16'h0, busy}, 32'h0000_FFFF);
    commit();
    apply(0, 32'h0, 1, 0, 4'h0);
    check("nop_valid", {31'h0, issue_valid}, 32'h1);
    commit();
    apply(0, 32'h0, 1, 0, 4'h0);
    check("nop_busy_kept", {16'h0, busy}, 32'h0000_FFFF);
    commit();

    // Backpressure: fields stay, slot refills on the cycle issue_ready returns
    do_reset();
    step(1, 32'h1567_1234, 1, 0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      apply(1, 32'h2ABC_5678, 0, 0, 4'h0);
      check("bp_ready_low", {31'h0, instr_ready}, 32'h0);
      check("bp_fields", {opcode, dest_sel, src1_sel, src2_sel, imm}, 32'h1567_1234);
      commit();
    end
    apply(1, 32'h2ABC_5678, 1, 0, 4'h0);
    check("bp_refill_ready", {31'h0, instr_ready}, 32'h1);
    commit();
    apply(0, 32'h0, 1, 0, 4'h0);
    check("bp_new_fields", {opcode, dest_sel, src1_sel, src2_sel, imm}, 32'h2ABC_5678);
    commit();

    // Set/clear collision on the same register: set wins
    do_reset();
    step(1, 32'h1500_0000, 1, 0, 4'h0);
    step(0, 32'h0, 1, 1, 4'h5);
    apply(0, 32'h0, 1, 0, 4'h0);
    check("collision_busy", {16'h0, busy}, 32'h0000_0020);
    commit();

    // Long hazard saturates stall_cnt, then reset mid-stall
    do_reset();
    step(1, 32'h1400_0000, 1, 0, 4'h0);
    step(0, 32'h0, 1, 0, 4'h0);
    step(1, 32'h2640_0000, 1, 0, 4'h0);
    for (int i = 0; i < 300; i++) step(0, 32'h0, 1, 0, 4'h0);
    apply(0, 32'h0, 1, 0, 4'h0);
    check("sat_stall", {24'h0, stall_cnt}, 32'h0000_00FF);
    check("sat_busy", {16'h0, busy}, 32'h0000_0010);
    check("sat_valid", {31'h0, issue_valid}, 32'h0);
    commit();
    do_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ri;
      ri = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 16'($urandom)};
      step(($urandom_range(0, 9) < 7), ri, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 7)));
      if (i == 1500) do_reset();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
